// File: rtl/pmu_cfg_arbiter.sv
// Round-robin arbiter for the PMU configuration write port; keeps a shadow register array.
// Optional ownership lock with idle timeout is enabled by defining PMU_CFG_ARB_LOCK_EN.
module pmu_cfg_arbiter #(
  parameter int N_REQ        = 4,
  parameter int REG_WIDTH    = 32,
  parameter int TOTAL_NREGS  = 47,
  parameter int LOCK_TIMEOUT = 16,
  localparam int AW = $clog2(TOTAL_NREGS),
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*AW-1:0]          addr_i,
  input  logic [N_REQ*REG_WIDTH-1:0]   data_i,
  input  logic [N_REQ-1:0]             lock_i,
  output logic [N_REQ-1:0]             gnt_o,
  output logic [REG_WIDTH-1:0]         regs_o [TOTAL_NREGS],
  output logic                         we_o,
  output logic                         err_o,
  output logic [OW-1:0]                owner_o
);

  logic [REG_WIDTH-1:0] r_regs [TOTAL_NREGS];
  logic                 r_we;
  logic                 r_err;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        r_ptr;

  logic [N_REQ-1:0]     w_elig;
  logic                 w_gntValid;
  logic [OW-1:0]        w_gntIdx;
  logic [OW-1:0]        w_cand;
  logic [OW-1:0]        w_nextPtr;
  logic [AW-1:0]        w_addr;
  logic [REG_WIDTH-1:0] w_data;
  logic                 w_addrOk;

`ifdef PMU_CFG_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic          r_locked;
  logic [OW-1:0] r_lockOwner;
  logic [CW-1:0] r_idle;
  logic          w_ownerReq;
  logic          w_lockTimeout;

  // While locked only the owner is eligible; everyone else waits.
  assign w_ownerReq    = req_i[r_lockOwner];
  assign w_lockTimeout = r_locked && !w_ownerReq && (r_idle == CW'(LOCK_TIMEOUT - 1));
  assign w_elig        = r_locked ? (req_i & (N_REQ'(1) << r_lockOwner)) : req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked    <= 1'b0;
      r_lockOwner <= '0;
      r_idle      <= '0;
    end else if (r_locked) begin
      if (w_gntValid) begin
        r_locked <= lock_i[w_gntIdx];
        r_idle   <= '0;
      end else if (w_ownerReq) begin
        r_idle <= '0;
      end else if (w_lockTimeout) begin
        r_locked <= 1'b0;
        r_idle   <= '0;
      end else if (r_idle != CW'(LOCK_TIMEOUT)) begin
        r_idle <= r_idle + 1'b1;
      end
    end else if (w_gntValid && lock_i[w_gntIdx]) begin
      r_locked    <= 1'b1;
      r_lockOwner <= w_gntIdx;
      r_idle      <= '0;
    end
  end
`else
  logic w_unusedLock;

  assign w_elig       = req_i;
  assign w_unusedLock = ^{lock_i, 1'(LOCK_TIMEOUT > 0)};
`endif

  // Search eligible requesters starting at the round-robin pointer.
  always_comb begin
    w_gntValid = 1'b0;
    w_gntIdx   = '0;
    w_cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = OW'((int'(r_ptr) + i) % N_REQ);
      if (!w_gntValid && w_elig[w_cand]) begin
        w_gntValid = 1'b1;
        w_gntIdx   = w_cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (w_gntValid && !rst_i) begin
      gnt_o[w_gntIdx] = 1'b1;
    end
  end

  assign w_nextPtr = OW'((int'(w_gntIdx) + 1) % N_REQ);
  assign w_addr    = AW'(addr_i >> (int'(w_gntIdx) * AW));
  assign w_data    = REG_WIDTH'(data_i >> (int'(w_gntIdx) * REG_WIDTH));
  assign w_addrOk  = (32'(w_addr) < 32'(TOTAL_NREGS));

  // Out-of-range writes still consume the grant but only raise the error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_regs  <= '{default: '0};
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      if (w_gntValid) begin
        r_ptr   <= w_nextPtr;
        r_owner <= w_gntIdx;
        if (w_addrOk) begin
          r_regs[w_addr] <= w_data;
          r_we           <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
`ifdef PMU_CFG_ARB_LOCK_EN
      else if (w_lockTimeout) begin
        r_ptr <= OW'((int'(r_lockOwner) + 1) % N_REQ);
      end
`endif
    end
  end

  assign regs_o  = r_regs;
  assign we_o    = r_we;
  assign err_o   = r_err;
  assign owner_o = r_owner;

endmodule

// File: tb/tb_pmu_cfg_arbiter.sv
// Scoreboard bench for pmu_cfg_arbiter: directed scenarios followed by randomized traffic.
// The reference model follows PMU_CFG_ARB_LOCK_EN the same way the design does.
module tb_pmu_cfg_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NR = 47;
  localparam int AW = 6;
  localparam int T  = 16;
`ifdef PMU_CFG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*AW-1:0] addr;
  logic [N*W-1:0] data;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic [W-1:0]   regs [NR];
  logic           we;
  logic           err;
  logic [1:0]     owner;

  always #5 clk = ~clk;

  pmu_cfg_arbiter #(
    .N_REQ(N), .REG_WIDTH(W), .TOTAL_NREGS(NR), .LOCK_TIMEOUT(T)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(data),
    .lock_i(lock), .gnt_o(gnt), .regs_o(regs), .we_o(we), .err_o(err),
    .owner_o(owner)
  );

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic            we;
    logic            err;
    logic [1:0]      owner;
    logic [NR*W-1:0] regs;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: array of registers plus arbitration bookkeeping.
  logic [W-1:0] mRegs [NR];
  bit           mWe, mErr, mLocked;
  int           mOwner, mPtr, mLockOwner, mIdle;

  // Requester intent: remaining writes and the write being presented.
  int           rem [N];
  logic [AW-1:0] curAddr [N];
  logic [W-1:0] curData [N];
  bit           curLock [N];

  task automatic modelReset();
    for (int j = 0; j < NR; j++) mRegs[j] = '0;
    mWe = 0; mErr = 0; mOwner = 0; mPtr = 0;
    mLocked = 0; mLockOwner = 0; mIdle = 0;
  endtask

  function automatic int modelPick(input logic [N-1:0] r);
    if (mLocked) return r[mLockOwner] ? mLockOwner : -1;
    for (int i = 0; i < N; i++) begin
      if (r[(mPtr + i) % N]) return (mPtr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [NR*W-1:0] packModel();
    logic [NR*W-1:0] p;
    for (int j = 0; j < NR; j++) p[j*W +: W] = mRegs[j];
    return p;
  endfunction

  task automatic setWrite(input int k, input int a, input logic [W-1:0] d, input bit l, input int n);
    curAddr[k] = AW'(a);
    curData[k] = d;
    curLock[k] = l;
    rem[k]     = n;
  endtask

  // Drive one cycle of inputs, queue what the DUT must show during it, then advance the model.
  task automatic applyStimulus(input bit doReset);
    logic [N-1:0] r;
    int k;
    exp_t e;
    @(posedge clk);
    #1;
    rst = doReset;
    for (int i = 0; i < N; i++) begin
      r[i] = (rem[i] > 0);
      req[i] = r[i];
      addr[i*AW +: AW] = curAddr[i];
      data[i*W +: W]   = curData[i];
      lock[i] = curLock[i];
    end
    k = doReset ? -1 : modelPick(r);
    e.gnt = '0;
    if (k >= 0) e.gnt[k] = 1'b1;
    e.we    = mWe;
    e.err   = mErr;
    e.owner = 2'(mOwner);
    e.regs  = packModel();
    expQ.push_back(e);
    if (doReset) begin
      modelReset();
      for (int i = 0; i < N; i++) rem[i] = 0;
    end else begin
      mWe = 0;
      mErr = 0;
      if (LOCK_EN) begin
        if (mLocked) begin
          if (k == mLockOwner) begin
            mLocked = curLock[k];
            mIdle = 0;
          end else if (r[mLockOwner]) begin
            mIdle = 0;
          end else begin
            mIdle++;
            if (mIdle == T) begin
              mLocked = 0;
              mIdle = 0;
              mPtr = (mLockOwner + 1) % N;
            end
          end
        end else if (k >= 0 && curLock[k]) begin
          mLocked = 1;
          mLockOwner = k;
          mIdle = 0;
        end
      end
      if (k >= 0) begin
        mPtr = (k + 1) % N;
        mOwner = k;
        if (int'(curAddr[k]) < NR) begin
          mRegs[curAddr[k]] = curData[k];
          mWe = 1;
        end else begin
          mErr = 1;
        end
        rem[k]--;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [NR*W-1:0] act;
    for (int j = 0; j < NR; j++) act[j*W +: W] = regs[j];
    total++;
    if (gnt !== e.gnt) begin
      bad++;
      $display("[TB] FAIL gnt: got %b want %b at %0t", gnt, e.gnt, $time);
    end
    total++;
    if (we !== e.we) begin
      bad++;
      $display("[TB] FAIL we: got %b want %b at %0t", we, e.we, $time);
    end
    total++;
    if (err !== e.err) begin
      bad++;
      $display("[TB] FAIL err: got %b want %b at %0t", err, e.err, $time);
    end
    if (e.we) begin
      total++;
      if (owner !== e.owner) begin
        bad++;
        $display("[TB] FAIL owner: got %0d want %0d at %0t", owner, e.owner, $time);
      end
    end
    total++;
    if (act !== e.regs) begin
      bad++;
      for (int j = 0; j < NR; j++) begin
        if (act[j*W +: W] !== e.regs[j*W +: W]) begin
          $display("[TB] FAIL regs[%0d]: got %h want %h at %0t", j, act[j*W +: W], e.regs[j*W +: W], $time);
          break;
        end
      end
    end
  endtask

  // Monitor: mid-cycle, compare what the DUT presents with the oldest queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  logic [W-1:0] pat [N];

  initial begin
    pat = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
    rst = 1'b1;
    req = '0;
    addr = '0;
    data = '0;
    lock = '0;
    for (int i = 0; i < N; i++) setWrite(i, 0, '0, 0, 0);
    modelReset();
    repeat (3) @(posedge clk);

    // Single write from requester 2.
    setWrite(2, 29, 32'h00000002, 0, 1);
    repeat (3) applyStimulus(0);

    // Everyone requesting: grants rotate one per cycle.
    applyStimulus(1);
    for (int i = 0; i < N; i++) setWrite(i, 30 + i, pat[i], 0, 2);
    repeat (10) applyStimulus(0);

    // Out-of-range address, then check priority resumes after requester 1.
    setWrite(1, 47, 32'h00001234, 0, 1);
    repeat (2) applyStimulus(0);
    for (int i = 0; i < N; i++) setWrite(i, 5 + i, $urandom, 0, 1);
    repeat (6) applyStimulus(0);

    // Reset lands on the grant cycle.
    setWrite(1, 38, 32'h01020304, 0, 1);
    applyStimulus(1);
    repeat (2) applyStimulus(0);

    // Lock then let the owner go idle past the timeout.
    setWrite(0, 43, 32'hDEAD0043, 1, 1);
    setWrite(3, 12, 32'h00003333, 0, 1);
    repeat (20) applyStimulus(0);

    // Lock then release with an explicit unlocked write.
    setWrite(0, 43, 32'hBEEF0043, 1, 1);
    setWrite(3, 13, 32'h00004444, 0, 1);
    applyStimulus(0);
    setWrite(0, 44, 32'h00000044, 0, 1);
    repeat (4) applyStimulus(0);

    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, (i == 0) ? 5 : 1) == 0) begin
          setWrite(i, $urandom_range(0, 63), $urandom, ($urandom_range(0, 3) == 0), 1);
        end
      end
      applyStimulus($urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (3) applyStimulus(0);

    @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmu_cfg_arbiter.md
# pmu_cfg_arbiter

Shares the single configuration write port of the PMU register block between several software/hardware requesters (bus wrapper, self-test sequencer, crossbar route programmer, MCCU quota refiller). Keeps a shadow copy of the full PMU register array, applies at most one granted register write per cycle using round-robin arbitration, and pulses the PMU write-enable so the PMU samples the updated array. Sits between the requesters and the PMU's `regs_i` / `wrapper_we_i` inputs.

## Interface
- `N_REQ`, 4, number of requesters (≥2).
- `REG_WIDTH`, 32, register data width.
- `TOTAL_NREGS`, 47, number of PMU registers. Address width `AW = $clog2(TOTAL_NREGS)`.
- `LOCK_TIMEOUT`, 16, idle cycles after which a held lock is dropped (≥1). Used only with the lock feature.

- `clk_i`  in  1  clock. All logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  N_REQ  per-requester write request. Held until granted.
- `addr_i`  in  N_REQ*AW  packed register index. Requester k uses bits `[k*AW +: AW]`.
- `data_i`  in  N_REQ*REG_WIDTH  packed write data. Requester k uses bits `[k*REG_WIDTH +: REG_WIDTH]`.
- `lock_i`  in  N_REQ  request to keep ownership after this write.
- `gnt_o`  out  N_REQ  one-hot grant, combinational, at most one bit high.
- `regs_o`  out  [REG_WIDTH-1:0] x TOTAL_NREGS  shadow register array. Drives the PMU `regs_i`.
- `we_o`  out  1  PMU write strobe. Drives `wrapper_we_i`.
- `err_o`  out  1  one-cycle pulse when a granted address is ≥ TOTAL_NREGS.
- `owner_o`  out  $clog2(N_REQ)  index of the last granted requester.

## Operation
- Handshake: a transfer from requester k occurs in any cycle where `req_i[k] && gnt_o[k]`. Addr and data must be stable while req is high. The requester may drop req, or present the next write, in the following cycle.
- Arbitration: round-robin over requesters with req high. Search starts at pointer `ptr`. After a grant to k, `ptr <= (k+1) mod N_REQ`. With no requests, no grant and `ptr` is unchanged.
- Commit, for a valid address:
  - `regs_o[addr] <= data` at the grant edge.
  - `we_o <= 1` for the next cycle.
  - `owner_o <= k`.
- Commit, for an invalid address (≥ TOTAL_NREGS):
  - Grant is still given and `ptr` still advances.
  - The shadow array is unchanged and `we_o` stays 0.
  - `err_o <= 1` for one cycle.
- `we_o` may stay high on consecutive cycles when writes are granted back-to-back. Throughput is one write per cycle.
- Shadow registers are never modified except by granted writes and reset.
- State machine (lock feature only):
  - UNLOCKED: normal round-robin.
  - UNLOCKED → LOCKED(k): on a granted write from k with `lock_i[k]=1`.
  - LOCKED(k): only requester k is eligible. Other requests wait.
  - LOCKED(k) → LOCKED(k): a granted write with `lock_i[k]=1` keeps the lock and clears the idle counter.
  - LOCKED(k) → UNLOCKED: on a granted write with `lock_i[k]=0`, or when `req_i[k]` has been low for `LOCK_TIMEOUT` consecutive cycles.
  - The idle counter saturates, counts only while `req_i[k]=0`, and clears on any `req_i[k]=1`.
  - On unlock, `ptr = (k+1) mod N_REQ`.

## Timing
- Reset values:
  - `regs_o` all zero.
  - `we_o=0`, `err_o=0`, `owner_o=0`.
  - `ptr=0`: requester 0 has first priority.
  - State UNLOCKED, idle counter 0.
  - `gnt_o` is 0 during the reset cycle, even if requests are high.
- Latency: request seen in cycle N → grant in cycle N (if chosen) → `regs_o` updated and `we_o=1` in cycle N+1. The PMU samples on edge N+2.
- All requesters requesting continuously: grants rotate 0,1,2,3,0,…, one per cycle.
- Two requesters writing the same address in successive cycles: the later grant wins. No two writes ever commit in the same cycle.
- Reset asserted mid-operation: the pending grant is cancelled (`gnt_o=0`), the shadow array is cleared, and any lock is dropped. Requesters must re-present.
- Timeout boundary: the lock is released at the edge where the counter reaches `LOCK_TIMEOUT`. Another requester may be granted in the next cycle.

## Configuration
- Macro: `PMU_CFG_ARB_LOCK_EN`.
- Defined: LOCKED state, idle counter and `LOCK_TIMEOUT` behave as described above.
- Undefined:
  - `lock_i` is ignored (port retained, unused) and the arbiter is always UNLOCKED.
  - No lock counter or lock state registers exist.

## Test plan
- Reset, then requester 2 writes addr 29 = 0x00000002 → `gnt_o=4'b0100` same cycle; next cycle `regs_o[29]=0x2`, `we_o=1` for exactly one cycle; all other regs 0.
- All 4 requesters high for 8 cycles, distinct addresses 30..33, data 0xFFFFFFFF/0xAAAAAAAA/0xBBBBBBBB/0xCCCCCCCC → grant order 0,1,2,3,0,1,2,3; `we_o` high 8 consecutive cycles; final regs 30..33 hold the respective values.
- Requester 1 writes addr 47 = 0x1234 → granted; `err_o=1` one cycle; `we_o=0`; no register changes; next grant priority starts at 2.
- Lock feature: requester 0 writes addr 43 with `lock_i=1` while requester 3 requests → requester 3 blocked; requester 0 idle 16 cycles → lock drops; requester 3 granted in the following cycle.
- Lock feature: locked requester 0 issues addr 44 with `lock_i=0` → granted, unlocked; requester 3 granted the next cycle. Without the macro, the same stimulus gives alternating 0/3 grants.
- Assert `rst_i` in the cycle requester 1 is granted addr 38 = 0x01020304 → `regs_o[38]` remains 0; `we_o=0`; `ptr=0` after reset.
